// File: rtl/bit_kosusu_pkg.sv
// Shared constants for the bit runner: heading codes and FSM state encodings.
// No logic; no latency; no flow control.
// Imported by bit_kosusu_gen.
package bit_kosusu_pkg;

  localparam logic [1:0] YON_KUZEY = 2'd0;
  localparam logic [1:0] YON_DOGU  = 2'd1;
  localparam logic [1:0] YON_GUNEY = 2'd2;
  localparam logic [1:0] YON_BATI  = 2'd3;

  typedef enum logic {
    DURUM_KOS   = 1'b0,
    DURUM_BITTI = 1'b1
  } durum_t;

endpackage

// File: rtl/kenar_algila.sv
// Single-bit synchronous rising-edge detector.
// Latency: kenar is combinational from d against the previous sampled value.
// Backpressure: none; one pulse per sampled 0->1 transition.
module kenar_algila (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic kenar
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign kenar = d & ~d_q;

endmodule

// File: rtl/bit_kosusu_gen.sv
// Bit runner on a 2^W x 2^W grid; BIT_KOSUSU_SARMA_EN selects wrap-around borders (default: blocking).
// Latency: one cycle from sampled ileri/don to x, y, yon, adim, bitti_mi.
// Backpressure: none; one step or one turn per cycle, a turn edge suppresses that cycle's step.
module bit_kosusu_gen #(
  parameter int unsigned W       = 8,
  parameter int unsigned AW      = 16,
  parameter logic [W-1:0] HEDEF_X = {W{1'b1}},
  parameter logic [W-1:0] HEDEF_Y = {W{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ileri,
  input  logic          don,
  input  logic          sol,
  output logic [1:0]    yon,
  output logic [1:0]    bolge,
  output logic [W-1:0]  x,
  output logic [W-1:0]  y,
  output logic [AW-1:0] adim,
  output logic          bitti_mi
);

  import bit_kosusu_pkg::*;

`ifdef BIT_KOSUSU_SARMA_EN
  localparam bit SARMA = 1'b1;
`else
  localparam bit SARMA = 1'b0;
`endif

  localparam logic [W-1:0]  KOORD_MAX = {W{1'b1}};
  localparam logic [W-1:0]  KOORD_BIR = {{(W-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADIM_MAX  = {AW{1'b1}};
  localparam logic [AW-1:0] ADIM_BIR  = {{(AW-1){1'b0}}, 1'b1};

  durum_t        durum, durum_n;
  logic          don_kenar;
  logic [W-1:0]  x_n, y_n, x_s, y_s;
  logic [1:0]    yon_n;
  logic [AW-1:0] adim_n;
  logic          sinirda;
  logic          adim_ok;

  kenar_algila u_don_kenar (
    .clk   (clk),
    .rst   (rst),
    .d     (don),
    .kenar (don_kenar)
  );

  // Candidate position one unit along the heading; arithmetic wraps mod 2^W.
  always_comb begin
    x_s     = x;
    y_s     = y;
    sinirda = 1'b0;
    unique case (yon)
      YON_KUZEY: begin y_s = y + KOORD_BIR; sinirda = (y == KOORD_MAX); end
      YON_DOGU:  begin x_s = x + KOORD_BIR; sinirda = (x == KOORD_MAX); end
      YON_GUNEY: begin y_s = y - KOORD_BIR; sinirda = (y == '0);        end
      default:   begin x_s = x - KOORD_BIR; sinirda = (x == '0);        end
    endcase
  end

  always_comb begin
    durum_n = durum;
    x_n     = x;
    y_n     = y;
    yon_n   = yon;
    adim_n  = adim;
    adim_ok = 1'b0;
    if (durum == DURUM_KOS) begin
      if (don_kenar) begin
        yon_n = sol ? (yon - 2'd1) : (yon + 2'd1);
      end else if (ileri) begin
        adim_ok = SARMA || !sinirda;
      end
      if (adim_ok) begin
        x_n    = x_s;
        y_n    = y_s;
        adim_n = (adim == ADIM_MAX) ? adim : (adim + ADIM_BIR);
        // Only a real move can arrive; the reset position never counts.
        if (x_s == HEDEF_X && y_s == HEDEF_Y) durum_n = DURUM_BITTI;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum <= DURUM_KOS;
      x     <= '0;
      y     <= '0;
      yon   <= YON_KUZEY;
      adim  <= '0;
    end else begin
      durum <= durum_n;
      x     <= x_n;
      y     <= y_n;
      yon   <= yon_n;
      adim  <= adim_n;
    end
  end

  assign bitti_mi = (durum == DURUM_BITTI);
  assign bolge    = {y[W-1], x[W-1]};

endmodule

// File: tb/tb_bit_kosusu_gen.sv
// Directed bench for bit_kosusu_gen with W=4, target (3,2); expectations follow BIT_KOSUSU_SARMA_EN.
module tb_bit_kosusu_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ileri = 1'b0;
  logic        don = 1'b0;
  logic        sol = 1'b0;
  logic [1:0]  yon;
  logic [1:0]  bolge;
  logic [3:0]  x;
  logic [3:0]  y;
  logic [15:0] adim;
  logic        bitti_mi;

  int tests_run = 0;
  int tests_failed = 0;

  bit_kosusu_gen #(
    .W       (4),
    .AW      (16),
    .HEDEF_X (4'd3),
    .HEDEF_Y (4'd2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ileri    (ileri),
    .don      (don),
    .sol      (sol),
    .yon      (yon),
    .bolge    (bolge),
    .x        (x),
    .y        (y),
    .adim     (adim),
    .bitti_mi (bitti_mi)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; ileri = 1'b0; don = 1'b0; sol = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ileri = 1'b1; don = 1'b1; sol = 1'b0;
    tick();
    tests_run++;
    if ({x, y, yon, bolge, adim, bitti_mi} !== {4'd0, 4'd0, 2'd0, 2'd0, 16'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset: got x=%0d y=%0d yon=%0d bolge=%0d adim=%0d bitti=%0d, want all 0",
               x, y, yon, bolge, adim, bitti_mi);
    end
    rst = 1'b0; ileri = 1'b0; don = 1'b0;
  endtask

  task automatic test_step_north;
    do_reset();
    ileri = 1'b1;
    tick();
    tests_run++;
    if ({x, y, adim} !== {4'd0, 4'd1, 16'd1}) begin
      tests_failed++;
      $display("FAIL step_latency: got x=%0d y=%0d adim=%0d, want x=0 y=1 adim=1", x, y, adim);
    end
    tick();
    tick();
    ileri = 1'b0;
    tests_run++;
    if ({x, y, yon, adim, bitti_mi} !== {4'd0, 4'd3, 2'd0, 16'd3, 1'b0}) begin
      tests_failed++;
      $display("FAIL step_north: got x=%0d y=%0d yon=%0d adim=%0d bitti=%0d, want 0 3 0 3 0",
               x, y, yon, adim, bitti_mi);
    end
  endtask

  task automatic test_turn_hold;
    do_reset();
    sol = 1'b0; don = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (yon !== 2'd1) begin
        tests_failed++;
        $display("FAIL turn_hold_cw[%0d]: got yon=%0d, want 1", i, yon);
      end
    end
    don = 1'b0;
    tick();
    sol = 1'b1; don = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (yon !== 2'd0) begin
        tests_failed++;
        $display("FAIL turn_hold_ccw[%0d]: got yon=%0d, want 0", i, yon);
      end
    end
    don = 1'b0; sol = 1'b0;
    tick();
  endtask

  task automatic test_turn_and_step;
    do_reset();
    ileri = 1'b1;
    tick();
    tick();
    don = 1'b1; sol = 1'b0;
    tick();
    tests_run++;
    if ({x, y, yon, adim} !== {4'd0, 4'd2, 2'd1, 16'd2}) begin
      tests_failed++;
      $display("FAIL turn_wins: got x=%0d y=%0d yon=%0d adim=%0d, want 0 2 1 2", x, y, yon, adim);
    end
    tick();
    tests_run++;
    if ({x, y, yon, adim} !== {4'd1, 4'd2, 2'd1, 16'd3}) begin
      tests_failed++;
      $display("FAIL step_after_turn: got x=%0d y=%0d yon=%0d adim=%0d, want 1 2 1 3", x, y, yon, adim);
    end
    ileri = 1'b0; don = 1'b0;
    tick();
  endtask

  task automatic test_border;
    logic [3:0]  exp_x, exp_y;
    logic [15:0] exp_a;
    logic [1:0]  exp_b;
    do_reset();
    sol = 1'b1; don = 1'b1;
    tick();
    don = 1'b0; sol = 1'b0;
    ileri = 1'b1;
    tick();
    ileri = 1'b0;
`ifdef BIT_KOSUSU_SARMA_EN
    exp_x = 4'd15; exp_a = 16'd1; exp_b = 2'b01;
`else
    exp_x = 4'd0;  exp_a = 16'd0; exp_b = 2'b00;
`endif
    tests_run++;
    if ({x, y, yon, adim, bolge} !== {exp_x, 4'd0, 2'd3, exp_a, exp_b}) begin
      tests_failed++;
      $display("FAIL border_west: got x=%0d y=%0d yon=%0d adim=%0d bolge=%0d, want x=%0d y=0 yon=3 adim=%0d bolge=%0d",
               x, y, yon, adim, bolge, exp_x, exp_a, exp_b);
    end

    do_reset();
    ileri = 1'b1;
    repeat (15) tick();
    tests_run++;
    if ({y, adim, bolge} !== {4'd15, 16'd15, 2'b10}) begin
      tests_failed++;
      $display("FAIL north_top: got y=%0d adim=%0d bolge=%0d, want y=15 adim=15 bolge=2", y, adim, bolge);
    end
    tick();
    ileri = 1'b0;
`ifdef BIT_KOSUSU_SARMA_EN
    exp_y = 4'd0;  exp_a = 16'd16; exp_b = 2'b00;
`else
    exp_y = 4'd15; exp_a = 16'd15; exp_b = 2'b10;
`endif
    tests_run++;
    if ({x, y, adim, bolge} !== {4'd0, exp_y, exp_a, exp_b}) begin
      tests_failed++;
      $display("FAIL border_north: got x=%0d y=%0d adim=%0d bolge=%0d, want x=0 y=%0d adim=%0d bolge=%0d",
               x, y, adim, bolge, exp_y, exp_a, exp_b);
    end
  endtask

  task automatic test_path;
    do_reset();
    ileri = 1'b1;
    tick();
    tick();
    ileri = 1'b0; don = 1'b1; sol = 1'b0;
    tick();
    don = 1'b0; ileri = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({x, y, bitti_mi} !== {4'd2, 4'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL path_before_target: got x=%0d y=%0d bitti=%0d, want 2 2 0", x, y, bitti_mi);
    end
    tick();
    tests_run++;
    if ({x, y, yon, adim, bitti_mi} !== {4'd3, 4'd2, 2'd1, 16'd5, 1'b1}) begin
      tests_failed++;
      $display("FAIL path_arrive: got x=%0d y=%0d yon=%0d adim=%0d bitti=%0d, want 3 2 1 5 1",
               x, y, yon, adim, bitti_mi);
    end
    tick();
    don = 1'b1; sol = 1'b1;
    tick();
    don = 1'b0;
    tick();
    tests_run++;
    if ({x, y, yon, adim, bitti_mi} !== {4'd3, 4'd2, 2'd1, 16'd5, 1'b1}) begin
      tests_failed++;
      $display("FAIL path_frozen: got x=%0d y=%0d yon=%0d adim=%0d bitti=%0d, want 3 2 1 5 1",
               x, y, yon, adim, bitti_mi);
    end
  endtask

  task automatic test_rst_recovery;
    rst = 1'b1; ileri = 1'b1;
    tick();
    tests_run++;
    if ({x, y, yon, adim, bitti_mi} !== {4'd0, 4'd0, 2'd0, 16'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_in_bitti: got x=%0d y=%0d yon=%0d adim=%0d bitti=%0d, want all 0",
               x, y, yon, adim, bitti_mi);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if ({y, adim, bitti_mi} !== {4'd1, 16'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL step_after_rst: got y=%0d adim=%0d bitti=%0d, want 1 1 0", y, adim, bitti_mi);
    end
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if ({x, y, yon, adim} !== {4'd0, 4'd0, 2'd0, 16'd0}) begin
      tests_failed++;
      $display("FAIL rst_mid_run: got x=%0d y=%0d yon=%0d adim=%0d, want all 0", x, y, yon, adim);
    end
    rst = 1'b0;
    tick();
    ileri = 1'b0;
    tests_run++;
    if ({y, adim} !== {4'd1, 16'd1}) begin
      tests_failed++;
      $display("FAIL step_after_mid_rst: got y=%0d adim=%0d, want 1 1", y, adim);
    end
  endtask

  initial begin
    test_reset();
    test_step_north();
    test_turn_hold();
    test_turn_and_step();
    test_border();
    test_path();
    test_rst_recovery();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
